booth_seq_ctrl: RTL and testbench

- Upstream control stage for the 4x4 signed Booth datapath. It accepts a start/operand handshake, registers both operands, and pulses the datapath load.
- It then scans the multiplier for Booth bit-pair transitions, skipping runs of equal bits. It issues exactly one add or subtract step per transition, with absolute multiplicand shift and relative multiplier shift amounts.
- Once no transition remains, it signals completion to the downstream consumer.

---
 rtl/booth_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_booth_seq_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_ctrl.sv
// Sequencing control for the 4x4 signed Booth datapath: operand handshake, load pulse and one
// add/sub step per multiplier bit-pair transition. Define BOOTH_SEQ_CTRL_STATS_EN for step_count.
module booth_seq_ctrl #(
    parameter int unsigned N  = 4,
    parameter int unsigned SW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  multiplicand_in,
    input  logic [N-1:0]  multiplier_in,
    output logic          ready,
    output logic [N-1:0]  mcand_q,
    output logic [N-1:0]  mplr_q,
    output logic          dp_load,
    output logic [SW-1:0] A_shift_amount,
    output logic [SW-1:0] B_shift_amount,
    output logic          op,
    output logic          done,
`ifdef BOOTH_SEQ_CTRL_STATS_EN
    output logic [SW-1:0] step_count,
`endif
    output logic          result_valid
);

    typedef enum logic [1:0] {StIdle, StLoad, StScan, StFinish} state_e;

    state_e        state_q;
    logic [SW-1:0] pos_q;
    logic [SW-1:0] last_q;

    logic [N-1:0]  pair_diff;
    logic          step_found;
    logic [SW-1:0] step_k;
    logic          step_op;
    logic          step_issue;

    // Bit k differs from bit k-1 (b[-1]=0) exactly where a Booth step is needed.
    assign pair_diff = mplr_q ^ {mplr_q[N-2:0], 1'b0};

    always_comb begin
        step_found = 1'b0;
        step_k     = '0;
        step_op    = 1'b0;
        // Descending scan so the lowest qualifying position is the one left selected.
        for (int k = N - 1; k >= 0; k--) begin
            if (pair_diff[k] && (k >= int'(pos_q))) begin
                step_found = 1'b1;
                step_k     = SW'(k);
                step_op    = ~mplr_q[k];
            end
        end
    end

    assign step_issue     = (state_q == StScan) && step_found;
    assign done           = ~step_issue;
    assign op             = step_issue & step_op;
    assign A_shift_amount = step_issue ? step_k : '0;
    assign B_shift_amount = step_issue ? (step_k - last_q) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            ready        <= 1'b1;
            dp_load      <= 1'b0;
            result_valid <= 1'b0;
            mcand_q      <= '0;
            mplr_q       <= '0;
            pos_q        <= '0;
            last_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        mcand_q <= multiplicand_in;
                        mplr_q  <= multiplier_in;
                        pos_q   <= '0;
                        last_q  <= '0;
                        ready   <= 1'b0;
                        dp_load <= 1'b1;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    dp_load <= 1'b0;
                    state_q <= StScan;
                end
                StScan: begin
                    if (step_found) begin
                        pos_q  <= step_k + SW'(1);
                        last_q <= step_k;
                    end else begin
                        result_valid <= 1'b1;
                        state_q      <= StFinish;
                    end
                end
                StFinish: begin
                    result_valid <= 1'b0;
                    ready        <= 1'b1;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef BOOTH_SEQ_CTRL_STATS_EN
    logic [SW-1:0] step_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            step_count_q <= '0;
        end else if (state_q == StLoad) begin
            step_count_q <= '0;
        end else if (step_issue) begin
            step_count_q <= step_count_q + SW'(1);
        end
    end

    assign step_count = step_count_q;
`endif

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl: directed table, random operands against a bit-pair
// model, plus abort and busy-start sequences.
module tb_booth_seq_ctrl;
    localparam int N  = 4;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [N-1:0]  multiplicand_in;
    logic [N-1:0]  multiplier_in;
    logic          ready;
    logic [N-1:0]  mcand_q;
    logic [N-1:0]  mplr_q;
    logic          dp_load;
    logic [SW-1:0] A_shift_amount;
    logic [SW-1:0] B_shift_amount;
    logic          op;
    logic          done;
    logic          result_valid;
`ifdef BOOTH_SEQ_CTRL_STATS_EN
    logic [SW-1:0] step_count;
`endif

    booth_seq_ctrl #(.N(N), .SW(SW)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .multiplicand_in (multiplicand_in),
        .multiplier_in   (multiplier_in),
        .ready           (ready),
        .mcand_q         (mcand_q),
        .mplr_q          (mplr_q),
        .dp_load         (dp_load),
        .A_shift_amount  (A_shift_amount),
        .B_shift_amount  (B_shift_amount),
        .op              (op),
        .done            (done),
`ifdef BOOTH_SEQ_CTRL_STATS_EN
        .step_count      (step_count),
`endif
        .result_valid    (result_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one operation, record issued steps, and compare them with a model derived from the
    // multiplier bits. acc_o is the product rebuilt from the observed steps.
    task automatic run_op(input logic [3:0] mc, input logic [3:0] mp, input bit disturb,
                          output logic [7:0] acc_o);
        int            exp_k[$];
        int            exp_op[$];
        int            exp_b[$];
        int            obs_k[$];
        int            obs_op[$];
        int            obs_b[$];
        int            prev_k;
        int            got;
        int            n;
        logic          prev_bit;
        logic signed [7:0] acc;
        logic signed [7:0] term;

        prev_bit = 1'b0;
        prev_k   = 0;
        for (int k = 0; k < N; k++) begin
            if (mp[k] != prev_bit) begin
                exp_k.push_back(k);
                exp_op.push_back(mp[k] ? 0 : 1);
                exp_b.push_back(k - prev_k);
                prev_k = k;
            end
            prev_bit = mp[k];
        end
        n = exp_k.size();

        @(negedge clk);
        chk("ready_idle", ready, 1);
        multiplicand_in = mc;
        multiplier_in   = mp;
        start           = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got   = 0;
        acc   = '0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            chk("dp_load", dp_load, (cyc == 1) ? 1 : 0);
            chk("ready_busy", ready, 0);
            chk("mplr_q", mplr_q, mp);
            chk("mcand_q", mcand_q, mc);
            if (!done) begin
                obs_k.push_back(int'(A_shift_amount));
                obs_op.push_back(int'(op));
                obs_b.push_back(int'(B_shift_amount));
                term = $signed({{4{mc[3]}}, mc}) <<< A_shift_amount;
                acc  = op ? acc + term : acc - term;
            end
            if (result_valid) begin
                got = cyc;
                break;
            end
            if (disturb && cyc == 2) begin
                start           = 1'b1;
                multiplicand_in = ~mc;
                multiplier_in   = ~mp;
            end
            if (disturb && cyc == 3) start = 1'b0;
            @(negedge clk);
        end
        if (got == 0) chk("timeout_result_valid", 0, 1);
        else chk("latency", got, n + 3);
        chk("step_total", obs_k.size(), n);
        for (int i = 0; i < n && i < obs_k.size(); i++) begin
            chk("step_k", obs_k[i], exp_k[i]);
            chk("step_op", obs_op[i], exp_op[i]);
            chk("step_bshift", obs_b[i], exp_b[i]);
        end
        @(negedge clk);
        chk("ready_after", ready, 1);
        chk("rv_pulse", result_valid, 0);
        chk("done_idle", done, 1);
`ifdef BOOTH_SEQ_CTRL_STATS_EN
        chk("step_count", step_count, n);
`endif
        acc_o = acc;
    endtask

    typedef struct {
        logic [3:0] mc;
        logic [3:0] mp;
        logic [7:0] res;
    } vec_t;

    vec_t tbl[4];

    initial begin
        logic [7:0] acc;
        logic [7:0] prod;
        logic [3:0] mc;
        logic [3:0] mp;

        tbl[0] = '{mc: 4'd3, mp: 4'b0101, res: 8'h0F};
        tbl[1] = '{mc: 4'd5, mp: 4'b0000, res: 8'h00};
        tbl[2] = '{mc: 4'd3, mp: 4'b1111, res: 8'hFD};
        tbl[3] = '{mc: 4'd7, mp: 4'b1000, res: 8'hC8};

        rst             = 1'b1;
        start           = 1'b0;
        multiplicand_in = '0;
        multiplier_in   = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 1);
        chk("rst_dp_load", dp_load, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_op", op, 0);
        chk("rst_ashift", A_shift_amount, 0);
        chk("rst_bshift", B_shift_amount, 0);
        chk("rst_mcand", mcand_q, 0);
        chk("rst_mplr", mplr_q, 0);
`ifdef BOOTH_SEQ_CTRL_STATS_EN
        chk("rst_step_count", step_count, 0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_op(tbl[i].mc, tbl[i].mp, 1'b0, acc);
            chk("table_result", acc, tbl[i].res);
        end

        // Start while busy must not re-sample operands.
        run_op(4'd3, 4'b0101, 1'b1, acc);
        chk("busy_start_result", acc, 8'h0F);

        // Abort during the second step of 3 x 0101.
        @(negedge clk);
        multiplicand_in = 4'd3;
        multiplier_in   = 4'b0101;
        start           = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_in_step2", int'(A_shift_amount) + (done ? 100 : 0), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", ready, 1);
        chk("abort_done", done, 1);
        chk("abort_dp_load", dp_load, 0);
        chk("abort_rv", result_valid, 0);
        chk("abort_mplr", mplr_q, 0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("abort_no_rv", result_valid, 0);
        end
        run_op(4'd3, 4'b0101, 1'b0, acc);
        chk("after_abort_result", acc, 8'h0F);

        for (int r = 0; r < 40; r++) begin
            mc   = 4'($urandom_range(0, 15));
            mp   = 4'($urandom_range(0, 15));
            prod = $signed({{4{mc[3]}}, mc}) * $signed({{4{mp[3]}}, mp});
            // Busy-start disturbance needs at least one step before FINISH.
            run_op(mc, mp, (mp != 4'd0) && (r % 4 == 0), acc);
            chk("rand_result", acc, prod);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
